// File: rtl/node_stack_mem.sv
// Per-node word store shared by up to eight neighbours: round-robin write grant,
// broadcast read with a single-word pop per edge, LIFO or FIFO ordering by MODE.
module node_stack_mem #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 32,
    parameter int PORTS = 4,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS*WIDTH-1:0]     inData,
    input  logic [PORTS-1:0]           ready,
    input  logic [PORTS-1:0]           done,
    output logic [PORTS-1:0]           recv,
    output logic [PORTS-1:0]           send,
    output logic [WIDTH-1:0]           outData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             grant_vld;
    logic [PW-1:0]    grant_idx;
    logic             push, pop;
    logic             is_empty, is_full;
    logic [AW-1:0]    top_addr, wr_addr, rd_addr;
    logic [WIDTH-1:0] wr_data;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // Round-robin search starting at rr_ptr_q; suppressed entirely in reset or when full.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            for (int p = 0; p < PORTS; p++) begin
                if (!grant_vld && (p == idx) && ready[p]) begin
                    grant_vld = 1'b1;
                    grant_idx = PW'(p);
                end
            end
        end
        if (!rst || is_full) begin
            grant_vld = 1'b0;
            grant_idx = '0;
        end
    end

    always_comb begin
        wr_data = '0;
        recv    = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_vld && (grant_idx == PW'(p))) begin
                recv[p] = 1'b1;
                wr_data = inData[p*WIDTH +: WIDTH];
            end
        end
    end

    assign push = grant_vld;
    // Any number of done bits removes exactly one word.
    assign pop  = rst && !is_empty && (|done);

    // Stack keeps its top at count-1; a simultaneous push overwrites the popped top.
    assign top_addr = AW'(count_q - 1'b1);
    assign wr_addr  = (MODE == 0) ? (pop ? top_addr : AW'(count_q)) : wr_ptr_q;
    assign rd_addr  = (MODE == 0) ? top_addr : rd_ptr_q;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (push) begin
            wr_ptr_d = wrap_inc(wr_ptr_q);
            rr_ptr_d = (grant_idx == PW'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (pop) rd_ptr_d = wrap_inc(rd_ptr_q);
    end

    // NOTE: clocked state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_addr] <= wr_data;
    end

    assign empty   = !rst || is_empty;
    assign full    = rst && is_full;
    assign send    = {PORTS{~empty}};
    assign outData = empty ? '0 : mem_q[rd_addr];
    assign count   = count_q;

endmodule

// File: tb/tb_node_stack_mem.sv
// Scoreboard bench for node_stack_mem: one LIFO (depth 32) and one FIFO (depth 5) instance
// driven by directed and random traffic against queue-based reference models.
module tb_node_stack_mem;
    localparam int W   = 11;
    localparam int P   = 4;
    localparam int D0  = 32;
    localparam int D1  = 5;
    localparam int PWW = P * W;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   ready0, done0, recv0, send0;
    logic [P-1:0]   ready1, done1, recv1, send1;
    logic [PWW-1:0] in0, in1;
    logic [W-1:0]   out0, out1;
    logic [5:0]     count0;
    logic [2:0]     count1;
    logic           full0, empty0, full1, empty1;

    int model0[$];
    int model1[$];
    int exp0[$];
    int exp1[$];
    int rr0, rr1;
    int n_cmp, n_bad;
    int pop_sum0;
    int e0, e1;

    node_stack_mem #(.WIDTH(W), .DEPTH(D0), .PORTS(P), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .inData(in0), .ready(ready0), .done(done0),
        .recv(recv0), .send(send0), .outData(out0), .count(count0),
        .full(full0), .empty(empty0)
    );

    node_stack_mem #(.WIDTH(W), .DEPTH(D1), .PORTS(P), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .inData(in1), .ready(ready1), .done(done1),
        .recv(recv1), .send(send1), .outData(out1), .count(count1),
        .full(full1), .empty(empty1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [PWW-1:0] on_port(input int p, input int v);
        logic [PWW-1:0] r;
        r = '0;
        r[p*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [PWW-1:0] all_ports(input int base);
        logic [PWW-1:0] r;
        for (int p = 0; p < P; p++) r[p*W +: W] = W'(base + p);
        return r;
    endfunction

    // One clock of stimulus to instance d, with expectations taken from the reference model.
    task automatic drive(input int d, input bit rst_v, input logic [P-1:0] rdy,
                         input logic [PWW-1:0] data, input logic [P-1:0] dn);
        int sz, depth, rr, grant, word;
        logic [P-1:0] exp_recv, a_recv, a_send;
        longint a_count, a_out, a_full, a_empty;
        @(posedge clk);
        #1;
        rst    = rst_v;
        ready0 = (d == 0) ? rdy : '0;
        done0  = (d == 0) ? dn  : '0;
        in0    = data;
        ready1 = (d == 1) ? rdy : '0;
        done1  = (d == 1) ? dn  : '0;
        in1    = data;
        sz     = (d == 0) ? model0.size() : model1.size();
        depth  = (d == 0) ? D0 : D1;
        rr     = (d == 0) ? rr0 : rr1;
        grant  = -1;
        if (rst_v && sz < depth)
            for (int k = 0; k < P; k++)
                if (grant < 0 && rdy[(rr + k) % P]) grant = (rr + k) % P;
        exp_recv = '0;
        if (grant >= 0) exp_recv[grant] = 1'b1;
        if (rst_v && sz > 0 && dn != '0) begin
            if (d == 0) exp0.push_back(model0[$]);
            else        exp1.push_back(model1[0]);
        end
        @(negedge clk);
        a_recv  = (d == 0) ? recv0  : recv1;
        a_send  = (d == 0) ? send0  : send1;
        a_count = (d == 0) ? longint'(count0) : longint'(count1);
        a_out   = (d == 0) ? longint'(out0)   : longint'(out1);
        a_full  = (d == 0) ? longint'(full0)  : longint'(full1);
        a_empty = (d == 0) ? longint'(empty0) : longint'(empty1);
        check($sformatf("recv%0d", d), a_recv, exp_recv);
        check($sformatf("count%0d", d), a_count, sz);
        check($sformatf("empty%0d", d), a_empty, (!rst_v || sz == 0) ? 1 : 0);
        check($sformatf("full%0d", d), a_full, (rst_v && sz == depth) ? 1 : 0);
        check($sformatf("send%0d", d), a_send, (rst_v && sz > 0) ? 4'hF : 4'h0);
        if (!rst_v || sz == 0) check($sformatf("out%0d_zero", d), a_out, 0);
        if (!rst_v) begin
            model0.delete();
            model1.delete();
            rr0 = 0;
            rr1 = 0;
        end else begin
            if (sz > 0 && dn != '0) begin
                if (d == 0) void'(model0.pop_back());
                else        void'(model1.pop_front());
            end
            if (grant >= 0) begin
                word = int'(data[grant*W +: W]);
                if (d == 0) begin model0.push_back(word); rr0 = (grant + 1) % P; end
                else        begin model1.push_back(word); rr1 = (grant + 1) % P; end
            end
        end
    endtask

    // Monitors: each observed pop is compared against the next queued expectation.
    always @(negedge clk) begin
        if ((done0 & send0) != '0) begin
            if (exp0.size() == 0) check("pop0_unexpected", 1, 0);
            else begin
                e0 = exp0.pop_front();
                check("pop0_data", out0, e0);
                pop_sum0 += int'(out0);
            end
        end
    end

    always @(negedge clk) begin
        if ((done1 & send1) != '0) begin
            if (exp1.size() == 0) check("pop1_unexpected", 1, 0);
            else begin
                e1 = exp1.pop_front();
                check("pop1_data", out1, e1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish before 500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit             rv;
        logic [P-1:0]   rdy, dn;
        logic [PWW-1:0] dat;
        rst = 1'b0;
        ready0 = '0; done0 = '0; in0 = '0;
        ready1 = '0; done1 = '0; in1 = '0;
        n_cmp = 0; n_bad = 0; pop_sum0 = 0; rr0 = 0; rr1 = 0;

        // Reset state, with ready/done asserted to show they are ignored.
        drive(0, 1'b0, 4'hF, all_ports(100), 4'hF);
        drive(1, 1'b0, 4'hF, all_ports(100), 4'hF);

        // LIFO fill past capacity on port 0, then drain: 31 down to 0.
        for (int i = 0; i < 40; i++) drive(0, 1'b1, 4'b0001, on_port(0, i), 4'b0000);
        pop_sum0 = 0;
        for (int i = 0; i < 32; i++) drive(0, 1'b1, 4'b0000, '0, 4'b0001);
        drive(0, 1'b1, 4'b0000, '0, 4'b0000);
        check("sum0", pop_sum0, 496);

        // Round-robin with all ports requesting from a fresh pointer.
        drive(0, 1'b0, 4'b0000, '0, 4'b0000);
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 4'hF, all_ports(16 * i), 4'b0000);
        for (int i = 0; i < 8; i++) drive(0, 1'b1, 4'b0000, '0, 4'b0001);

        // Simultaneous push and pop on the stack: B replaced by C.
        drive(0, 1'b1, 4'b0001, on_port(0, 11'h0AA), 4'b0000);
        drive(0, 1'b1, 4'b0001, on_port(0, 11'h0BB), 4'b0000);
        drive(0, 1'b1, 4'b0100, on_port(2, 11'h0CC), 4'b0010);
        drive(0, 1'b1, 4'b0000, '0, 4'b0001);
        drive(0, 1'b1, 4'b0000, '0, 4'b0001);

        // All done bits with 3 words removes one; done while empty is ignored.
        for (int i = 0; i < 3; i++) drive(0, 1'b1, 4'b0010, on_port(1, 11'h7F0 + i), 4'b0000);
        drive(0, 1'b1, 4'b0000, '0, 4'hF);
        drive(0, 1'b1, 4'b0000, '0, 4'b0000);
        drive(0, 1'b1, 4'b0000, '0, 4'b1000);
        drive(0, 1'b1, 4'b0000, '0, 4'b0100);
        drive(0, 1'b1, 4'b0000, '0, 4'hF);
        drive(0, 1'b1, 4'b0000, '0, 4'b0000);

        // Reset mid-operation with 7 words and active ready/done.
        for (int i = 0; i < 7; i++) drive(0, 1'b1, 4'hF, all_ports(200 + 4 * i), 4'b0000);
        drive(0, 1'b0, 4'hF, all_ports(300), 4'hF);
        drive(0, 1'b1, 4'b0000, '0, 4'b0000);

        // FIFO depth 5: order preserved across pointer wrap.
        for (int i = 1; i <= 5; i++) drive(1, 1'b1, 4'b0001 << (i % P), on_port(i % P, i), 4'b0000);
        drive(1, 1'b1, 4'b0000, '0, 4'b0001);
        drive(1, 1'b1, 4'b0000, '0, 4'b0001);
        drive(1, 1'b1, 4'b0001, on_port(0, 6), 4'b0000);
        drive(1, 1'b1, 4'b0010, on_port(1, 7), 4'b0000);
        for (int i = 0; i < 6; i++) drive(1, 1'b1, 4'b0000, '0, 4'b0001);

        // Random traffic: push-heavy then pop-heavy, occasional reset.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 500; i++) begin
                rv  = ($urandom_range(0, 99) != 0);
                dat = PWW'({$urandom(), $urandom()});
                if (i < 250) begin
                    rdy = ($urandom_range(0, 4) != 0) ? P'($urandom()) : '0;
                    dn  = ($urandom_range(0, 5) == 0) ? P'($urandom()) : '0;
                end else begin
                    rdy = ($urandom_range(0, 3) == 0) ? P'($urandom()) : '0;
                    dn  = ($urandom_range(0, 3) != 0) ? P'($urandom()) : '0;
                end
                drive(d, rv, rdy, dat, dn);
            end
        end
        drive(0, 1'b1, 4'b0000, '0, 4'b0000);

        check("exp0_left", exp0.size(), 0);
        check("exp1_left", exp1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/node_stack_mem.md
NODE_STACK_MEM -- requirements
Module: node_stack_mem

Interface
REQ-001 Parameter WIDTH, default 11: data word width in bits.
REQ-002 Parameter DEPTH, default 32: storage capacity in words; any integer >= 2, not restricted to a power of two.
REQ-003 Parameter PORTS, default 4: neighbour channel count, range 1..8.
REQ-004 Parameter MODE, default 0: 0 = LIFO stack, 1 = FIFO queue.
REQ-005 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 inData  input  PORTS*WIDTH  neighbour write data, port i at bits [i*WIDTH +: WIDTH].
REQ-008 ready  input  PORTS  neighbour i has a word on inData for this node.
REQ-009 done  input  PORTS  neighbour i takes outData this cycle.
REQ-010 recv  output  PORTS  this node accepts port i's word at the coming edge.
REQ-011 send  output  PORTS  this node offers outData to neighbour i.
REQ-012 outData  output  WIDTH  word on offer to all neighbours.
REQ-013 count  output  clog2(DEPTH+1)  number of stored words.
REQ-014 full, empty  output  1 each  count==DEPTH and count==0 respectively.

Function
REQ-015 Write grant: when not full, exactly one port with ready high is granted per cycle, chosen round-robin starting from the port after the last granted port (pointer starts at 0).
REQ-016 recv is combinational: recv[i]=1 only for the granted port in the same cycle; the word is written at that edge.
REQ-017 When full, recv shall be all-zero and the round-robin pointer shall not move.
REQ-018 send[i] = ~empty for every i, combinationally, with no registered delay.
REQ-019 outData is the top of stack in MODE 0 and the oldest word in MODE 1; outData is 0 when empty.
REQ-020 Pop: at an edge where (done & send) is non-zero, exactly one word is removed, however many done bits are set.
REQ-021 done while empty is ignored.
REQ-022 Simultaneous push and pop, MODE 0: the presented top is removed, the new word becomes top, and count is unchanged.
REQ-023 Simultaneous push and pop, MODE 1: the head is removed, the new word is appended at the tail, and count is unchanged.
REQ-024 FIFO pointers wrap modulo DEPTH.
REQ-025 Data is stored and returned bit-exact at WIDTH bits, with no arithmetic applied.
REQ-026 Push only (no pop): count increments by 1.
REQ-027 Pop only (no push): count decrements by 1.
REQ-028 count shall never exceed DEPTH and shall never underflow below 0.
REQ-029 The latency from a word being written to that word appearing on outData (if it is at the head/top) is 1 cycle.

Reset
REQ-030 At an edge with rst=0: count=0, FIFO pointers=0 and round-robin pointer=0; storage contents are don't-care.
REQ-031 During and immediately after reset: send=0, recv=0, outData=0, empty=1 and full=0.
REQ-032 While rst=0, ready and done are ignored and recv is held at 0.
REQ-033 Reset mid-operation discards all stored words; no partial pop or push completes at the reset edge.

Verification
REQ-034 MODE 0, DEPTH 32: push 0..39 on port 0 -> recv high for 32 words then stops, full=1; popping all words via done[0] yields 31 down to 0, sum 496, then empty=1 and send=0.
REQ-035 MODE 1, DEPTH 5: push 1..5, pop 2, push 6,7 -> pop order 1,2,3,4,5,6,7 across pointer wrap, count peaks at 5.
REQ-036 ready=4'b1111 held with distinct data, not full -> grants in order 0,1,2,3,0,... with one recv bit per cycle.
REQ-037 MODE 0, stack holds [A,B] with B on top; push C while done[1]=1 -> B removed, top=C, count=2.
REQ-038 done=4'b1111 for one cycle with 3 words stored -> count=2; done with empty -> count stays 0.
REQ-039 rst=0 asserted for one edge with count=7 and ready high -> next cycle count=0, send=0, recv=0 during reset, outData=0.
